// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer: FSM states,
// standard mcause codes and mtvec mode encodings.
package trap_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      TRAP     = 2'd1,
      REDIRECT = 2'd2,
      MRET     = 2'd3
   } trap_state_e;

   localparam int CAUSE_ECALL_M = 11;
   localparam int CAUSE_MEI     = 11;
   localparam int CAUSE_MTI     = 7;

   localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
   localparam logic [1:0] MTVEC_VECTORED = 2'b01;

endpackage

// File: rtl/trap_ctrl_if.sv
// Signal bundle between the core (MEM stage, CSR file, PC mux) and the
// trap sequencer. The core side is master, the sequencer is slave.
interface trap_ctrl_if #(
   parameter int XLEN = 32
);
   // MEM stage and interrupt inputs
   logic            mem_valid;
   logic [XLEN-1:0] mem_pc;
   logic            mem_ecall;
   logic            mem_mret;
   logic            ext_irq;
   logic            tmr_irq;
   // current CSR state
   logic            mstatus_mie;
   logic            mie_meie;
   logic            mie_mtie;
   logic [XLEN-1:0] mtvec;
   logic [XLEN-1:0] mepc_in;
   // pipeline control and CSR updates
   logic            flush;
   logic            redirect_en;
   logic [XLEN-1:0] redirect_pc;
   logic            mepc_we;
   logic [XLEN-1:0] mepc_wdata;
   logic            mcause_we;
   logic [XLEN-1:0] mcause_wdata;
   logic            mstatus_trap;
   logic            mstatus_mret;
   logic            busy;

   modport master (
      output mem_valid, mem_pc, mem_ecall, mem_mret, ext_irq, tmr_irq,
             mstatus_mie, mie_meie, mie_mtie, mtvec, mepc_in,
      input  flush, redirect_en, redirect_pc, mepc_we, mepc_wdata,
             mcause_we, mcause_wdata, mstatus_trap, mstatus_mret, busy
   );

   modport slave (
      input  mem_valid, mem_pc, mem_ecall, mem_mret, ext_irq, tmr_irq,
             mstatus_mie, mie_meie, mie_mtie, mtvec, mepc_in,
      output flush, redirect_en, redirect_pc, mepc_we, mepc_wdata,
             mcause_we, mcause_wdata, mstatus_trap, mstatus_mret, busy
   );

endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer. Takes ECALL, MRET and enabled interrupts from
// the MEM stage, then walks TRAP (CSR writes) -> REDIRECT (fetch handler), or
// MRET (fetch mepc). Outputs are a pure decode of the state and the values
// captured at detection, so an asynchronous reset silences them at once.
module trap_ctrl
   import trap_ctrl_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int ECALL_CAUSE = CAUSE_ECALL_M,
   parameter int EXT_CAUSE   = CAUSE_MEI,
   parameter int TMR_CAUSE   = CAUSE_MTI
) (
   input  logic         clk,
   input  logic         rst,
   trap_ctrl_if.slave   bus
);

   localparam logic [XLEN-2:0] LP_ECALL = (XLEN-1)'(ECALL_CAUSE);
   localparam logic [XLEN-2:0] LP_EXT   = (XLEN-1)'(EXT_CAUSE);
   localparam logic [XLEN-2:0] LP_TMR   = (XLEN-1)'(TMR_CAUSE);

   trap_state_e     r_state;
   logic [XLEN-1:0] r_cap_epc;
   logic [XLEN-2:0] r_cap_cause;
   logic            r_cap_irq;

   logic            w_ext_p;
   logic            w_tmr_p;
   logic            w_irq_p;
   logic [XLEN-1:0] w_tvec_base;
   logic [XLEN-1:0] w_vec_off;
   logic            w_vectored;
   logic            w_unused;

   logic            w_flush;
   logic            w_redirect_en;
   logic [XLEN-1:0] w_redirect_pc;
   logic            w_mepc_we;
   logic [XLEN-1:0] w_mepc_wdata;
   logic            w_mcause_we;
   logic [XLEN-1:0] w_mcause_wdata;
   logic            w_mstatus_trap;
   logic            w_mstatus_mret;

   assign w_ext_p = bus.ext_irq & bus.mie_meie;
   assign w_tmr_p = bus.tmr_irq & bus.mie_mtie;
   assign w_irq_p = bus.mstatus_mie & (w_ext_p | w_tmr_p);

   // Modes 10 and 11 fall through to direct; only 01 vectors, and only for interrupts.
   assign w_tvec_base = {bus.mtvec[XLEN-1:2], 2'b00};
   assign w_vec_off   = XLEN'({r_cap_cause, 2'b00});
   assign w_vectored  = (bus.mtvec[1:0] == MTVEC_VECTORED) && r_cap_irq;

   // mepc is always word aligned on return; its low bits are never used.
   assign w_unused = ^bus.mepc_in[1:0];

   // Sequencer state and trap capture; new traps are only accepted from IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_cap_epc   <= '0;
         r_cap_cause <= '0;
         r_cap_irq   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.mem_valid) begin
                  if (bus.mem_ecall) begin
                     r_cap_epc   <= bus.mem_pc;
                     r_cap_cause <= LP_ECALL;
                     r_cap_irq   <= 1'b0;
                     r_state     <= TRAP;
                  end else if (bus.mem_mret) begin
                     r_state     <= MRET;
                  end else if (w_irq_p) begin
                     // The MEM instruction is squashed and re-executed after return.
                     r_cap_epc   <= bus.mem_pc;
                     r_cap_cause <= w_ext_p ? LP_EXT : LP_TMR;
                     r_cap_irq   <= 1'b1;
                     r_state     <= TRAP;
                  end
               end
            end
            TRAP:     r_state <= REDIRECT;
            REDIRECT: r_state <= IDLE;
            MRET:     r_state <= IDLE;
            default:  r_state <= IDLE;
         endcase
      end
   end

   // Output decode from state and captured trap information.
   always_comb begin
      w_flush        = 1'b0;
      w_redirect_en  = 1'b0;
      w_redirect_pc  = '0;
      w_mepc_we      = 1'b0;
      w_mepc_wdata   = '0;
      w_mcause_we    = 1'b0;
      w_mcause_wdata = '0;
      w_mstatus_trap = 1'b0;
      w_mstatus_mret = 1'b0;
      case (r_state)
         TRAP: begin
            w_flush        = 1'b1;
            w_mepc_we      = 1'b1;
            w_mepc_wdata   = r_cap_epc;
            w_mcause_we    = 1'b1;
            w_mcause_wdata = {r_cap_irq, r_cap_cause};
            w_mstatus_trap = 1'b1;
         end
         REDIRECT: begin
            w_flush       = 1'b1;
            w_redirect_en = 1'b1;
            w_redirect_pc = w_vectored ? (w_tvec_base + w_vec_off) : w_tvec_base;
         end
         MRET: begin
            w_flush        = 1'b1;
            w_redirect_en  = 1'b1;
            w_redirect_pc  = {bus.mepc_in[XLEN-1:2], 2'b00};
            w_mstatus_mret = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign bus.flush        = w_flush;
   assign bus.redirect_en  = w_redirect_en;
   assign bus.redirect_pc  = w_redirect_pc;
   assign bus.mepc_we      = w_mepc_we;
   assign bus.mepc_wdata   = w_mepc_wdata;
   assign bus.mcause_we    = w_mcause_we;
   assign bus.mcause_wdata = w_mcause_wdata;
   assign bus.mstatus_trap = w_mstatus_trap;
   assign bus.mstatus_mret = w_mstatus_mret;
   assign bus.busy         = (r_state != IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Testbench for trap_ctrl: expected per-cycle output snapshots are queued
// when stimulus is applied and compared as each cycle's outputs settle.
module tb_trap_ctrl;

   typedef struct packed {
      logic        flush;
      logic        redirect_en;
      logic [31:0] redirect_pc;
      logic        mepc_we;
      logic [31:0] mepc_wdata;
      logic        mcause_we;
      logic [31:0] mcause_wdata;
      logic        mstatus_trap;
      logic        mstatus_mret;
      logic        busy;
   } out_t;

   typedef struct {
      logic [31:0] mtvec;
      int          kind;   // 0 ecall, 1 external, 2 timer
      logic [31:0] pc;
      logic [31:0] cause;
      logic [31:0] target;
   } mode_vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk  = 0;
   int   n_pass = 0;
   out_t sb[$];

   trap_ctrl_if #(.XLEN(32)) tif();

   trap_ctrl #(.XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (tif)
   );

   always #5 clk = ~clk;

   function automatic out_t obs();
      out_t o;
      o.flush        = tif.flush;
      o.redirect_en  = tif.redirect_en;
      o.redirect_pc  = tif.redirect_pc;
      o.mepc_we      = tif.mepc_we;
      o.mepc_wdata   = tif.mepc_wdata;
      o.mcause_we    = tif.mcause_we;
      o.mcause_wdata = tif.mcause_wdata;
      o.mstatus_trap = tif.mstatus_trap;
      o.mstatus_mret = tif.mstatus_mret;
      o.busy         = tif.busy;
      return o;
   endfunction

   function automatic out_t e_idle();
      out_t o = '0;
      return o;
   endfunction

   function automatic out_t e_trap(logic [31:0] epc, logic [31:0] cause);
      out_t o = '0;
      o.flush = 1'b1; o.mepc_we = 1'b1; o.mepc_wdata = epc;
      o.mcause_we = 1'b1; o.mcause_wdata = cause; o.mstatus_trap = 1'b1; o.busy = 1'b1;
      return o;
   endfunction

   function automatic out_t e_redir(logic [31:0] pc);
      out_t o = '0;
      o.flush = 1'b1; o.redirect_en = 1'b1; o.redirect_pc = pc; o.busy = 1'b1;
      return o;
   endfunction

   function automatic out_t e_mret(logic [31:0] pc);
      out_t o = '0;
      o.flush = 1'b1; o.redirect_en = 1'b1; o.redirect_pc = pc;
      o.mstatus_mret = 1'b1; o.busy = 1'b1;
      return o;
   endfunction

   task automatic clear_inputs();
      tif.mem_valid = 1'b0; tif.mem_pc = '0; tif.mem_ecall = 1'b0; tif.mem_mret = 1'b0;
      tif.ext_irq = 1'b0; tif.tmr_irq = 1'b0; tif.mstatus_mie = 1'b0;
      tif.mie_meie = 1'b0; tif.mie_mtie = 1'b0;
   endtask

   task automatic test_reset();
      out_t exp, got;
      tif.mem_valid = 1'b1; tif.mem_ecall = 1'b1; tif.mem_pc = 32'h100;
      tif.ext_irq = 1'b1; tif.tmr_irq = 1'b1; tif.mstatus_mie = 1'b1;
      tif.mie_meie = 1'b1; tif.mie_mtie = 1'b1;
      for (int c = 0; c < 4; c++) sb.push_back(e_idle());
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c == 2) begin
            rst = 1'b1;
            tif.mem_valid = 1'b0;
         end
         #1; exp = sb.pop_front(); got = obs(); n_chk++;
         if (got !== exp) $display("FAIL reset cyc%0d got %h exp %h", c, got, exp);
         else n_pass++;
      end
      clear_inputs();
   endtask

   task automatic test_ecall();
      out_t exp, got;
      @(negedge clk);
      tif.mem_valid = 1'b1; tif.mem_ecall = 1'b1; tif.mem_pc = 32'h100; tif.mtvec = 32'h200;
      sb.push_back(e_idle());
      sb.push_back(e_trap(32'h100, 32'd11));
      sb.push_back(e_redir(32'h200));
      sb.push_back(e_idle());
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 1) clear_inputs();
         #1; exp = sb.pop_front(); got = obs(); n_chk++;
         if (got !== exp) $display("FAIL ecall cyc%0d got %h exp %h", c, got, exp);
         else n_pass++;
      end
   endtask

   task automatic test_vectored_timer();
      out_t exp, got;
      @(negedge clk);
      tif.mem_valid = 1'b1; tif.mem_pc = 32'h40; tif.mtvec = 32'h301;
      tif.mstatus_mie = 1'b1; tif.mie_mtie = 1'b1; tif.tmr_irq = 1'b1;
      sb.push_back(e_idle());
      sb.push_back(e_trap(32'h40, 32'h8000_0007));
      sb.push_back(e_redir(32'h31C));
      sb.push_back(e_idle());
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 1) clear_inputs();
         #1; exp = sb.pop_front(); got = obs(); n_chk++;
         if (got !== exp) $display("FAIL vec_timer cyc%0d got %h exp %h", c, got, exp);
         else n_pass++;
      end
   endtask

   task automatic test_priority();
      out_t exp, got;
      @(negedge clk);
      tif.mem_valid = 1'b1; tif.mem_ecall = 1'b1; tif.mem_pc = 32'h500; tif.mtvec = 32'h600;
      tif.mstatus_mie = 1'b1; tif.mie_meie = 1'b1; tif.mie_mtie = 1'b1;
      tif.ext_irq = 1'b1; tif.tmr_irq = 1'b1;
      sb.push_back(e_idle());
      sb.push_back(e_trap(32'h500, 32'd11));
      sb.push_back(e_redir(32'h600));
      sb.push_back(e_idle());
      sb.push_back(e_trap(32'h504, 32'h8000_000B));
      sb.push_back(e_redir(32'h600));
      sb.push_back(e_idle());
      for (int c = 0; c < 7; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 1) begin
            tif.mem_ecall = 1'b0;
            tif.mem_pc = 32'h504;
         end
         if (c == 4) clear_inputs();
         #1; exp = sb.pop_front(); got = obs(); n_chk++;
         if (got !== exp) $display("FAIL priority cyc%0d got %h exp %h", c, got, exp);
         else n_pass++;
      end
   endtask

   task automatic test_mret_irq();
      out_t exp, got;
      @(negedge clk);
      tif.mem_valid = 1'b1; tif.mem_mret = 1'b1; tif.mem_pc = 32'h300;
      tif.mepc_in = 32'h104; tif.mtvec = 32'h200;
      tif.mstatus_mie = 1'b0; tif.mie_mtie = 1'b1; tif.tmr_irq = 1'b1;
      sb.push_back(e_idle());
      sb.push_back(e_mret(32'h104));
      sb.push_back(e_idle());
      sb.push_back(e_trap(32'h108, 32'h8000_0007));
      sb.push_back(e_redir(32'h200));
      sb.push_back(e_idle());
      for (int c = 0; c < 6; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 1) begin
            tif.mem_mret = 1'b0;
            tif.mstatus_mie = 1'b1;
            tif.mem_pc = 32'h108;
         end
         if (c == 3) clear_inputs();
         #1; exp = sb.pop_front(); got = obs(); n_chk++;
         if (got !== exp) $display("FAIL mret_irq cyc%0d got %h exp %h", c, got, exp);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_trap();
      out_t exp, got;
      @(negedge clk);
      tif.mem_valid = 1'b1; tif.mem_ecall = 1'b1; tif.mem_pc = 32'h80; tif.mtvec = 32'h200;
      sb.push_back(e_idle());
      sb.push_back(e_trap(32'h80, 32'd11));
      for (int c = 0; c < 6; c++) sb.push_back(e_idle());
      for (int c = 0; c < 8; c++) begin
         if (c != 0 && c != 2) @(negedge clk);
         if (c == 1) clear_inputs();
         if (c == 2) rst = 1'b0;
         if (c == 4) rst = 1'b1;
         #1; exp = sb.pop_front(); got = obs(); n_chk++;
         if (got !== exp) $display("FAIL reset_mid cyc%0d got %h exp %h", c, got, exp);
         else n_pass++;
      end
   endtask

   task automatic test_bubble();
      out_t exp, got;
      @(negedge clk);
      tif.mem_valid = 1'b0; tif.mem_pc = 32'h900; tif.mem_ecall = 1'b1;
      tif.mstatus_mie = 1'b1; tif.mie_meie = 1'b1; tif.ext_irq = 1'b1;
      for (int c = 0; c < 3; c++) sb.push_back(e_idle());
      for (int c = 0; c < 3; c++) begin
         if (c > 0) @(negedge clk);
         #1; exp = sb.pop_front(); got = obs(); n_chk++;
         if (got !== exp) $display("FAIL bubble cyc%0d got %h exp %h", c, got, exp);
         else n_pass++;
      end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_mtvec_modes();
      out_t exp, got;
      mode_vec_t tbl[4];
      tbl[0] = '{32'hFFFF_FFF1, 1, 32'h700, 32'h8000_000B, 32'h0000_001C};
      tbl[1] = '{32'h0000_0403, 2, 32'h704, 32'h8000_0007, 32'h0000_0400};
      tbl[2] = '{32'h0000_0302, 2, 32'h708, 32'h8000_0007, 32'h0000_0300};
      tbl[3] = '{32'h0000_0301, 0, 32'h70C, 32'd11,        32'h0000_0300};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tif.mtvec = tbl[i].mtvec; tif.mem_valid = 1'b1; tif.mem_pc = tbl[i].pc;
         if (tbl[i].kind == 0) tif.mem_ecall = 1'b1;
         else begin
            tif.mstatus_mie = 1'b1;
            if (tbl[i].kind == 1) begin tif.mie_meie = 1'b1; tif.ext_irq = 1'b1; end
            else begin tif.mie_mtie = 1'b1; tif.tmr_irq = 1'b1; end
         end
         sb.push_back(e_idle());
         sb.push_back(e_trap(tbl[i].pc, tbl[i].cause));
         sb.push_back(e_redir(tbl[i].target));
         sb.push_back(e_idle());
         for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) clear_inputs();
            #1; exp = sb.pop_front(); got = obs(); n_chk++;
            if (got !== exp)
               $display("FAIL mtvec_mode%0d cyc%0d got %h exp %h", i, c, got, exp);
            else n_pass++;
         end
      end
   endtask

   initial begin
      clear_inputs();
      tif.mtvec = '0;
      tif.mepc_in = '0;
      rst = 1'b0;
      test_reset();
      test_ecall();
      test_vectored_timer();
      test_priority();
      test_mret_irq();
      test_reset_mid_trap();
      test_bubble();
      test_mtvec_modes();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap sequencer for the 5-stage pipelined RV32I core with CSRs.
- Watches the MEM stage for ECALL and MRET, and watches the interrupt lines.
- Drives pipeline flush, PC redirect and the CSR-file trap updates (mepc, mcause, mstatus MIE/MPIE).
- Sits beside the hazard unit. Its flush and redirect outputs override normal PC selection.

Parameters:
- XLEN, 32, datapath and CSR width.
- ECALL_CAUSE, 11, mcause value for an environment call from M-mode.
- EXT_CAUSE, 11, interrupt code for a machine external interrupt (mcause MSB set).
- TMR_CAUSE, 7, interrupt code for a machine timer interrupt (mcause MSB set).

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- mem_valid  in  1  MEM stage holds a valid instruction
- mem_pc  in  XLEN  PC of the MEM-stage instruction
- mem_ecall  in  1  MEM instruction is ECALL (qualified by mem_valid)
- mem_mret  in  1  MEM instruction is MRET (qualified by mem_valid)
- ext_irq  in  1  external interrupt, level
- tmr_irq  in  1  timer interrupt, level
- mstatus_mie  in  1  current mstatus.MIE
- mie_meie  in  1  mie.MEIE
- mie_mtie  in  1  mie.MTIE
- mtvec  in  XLEN  current mtvec
- mepc_in  in  XLEN  current mepc
- flush  out  1  squash IF/ID/EX/MEM, suppress MEM store and WB write
- redirect_en  out  1  PC mux select for redirect_pc
- redirect_pc  out  XLEN  new fetch PC
- mepc_we  out  1  write mepc_wdata to mepc
- mepc_wdata  out  XLEN  trapping PC
- mcause_we  out  1  write mcause_wdata to mcause
- mcause_wdata  out  XLEN  trap cause
- mstatus_trap  out  1  CSR file does MPIE<=MIE, MIE<=0
- mstatus_mret  out  1  CSR file does MIE<=MPIE, MPIE<=1
- busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, TRAP, REDIRECT, MRET.
- Outputs decode combinationally from the state and the captured registers (cap_epc, cap_cause, cap_irq).
- In IDLE, every output is 0.
- Reset: state=IDLE, captured registers=0, every output 0. Reset asserted mid-sequence aborts the sequence; no partial CSR writes are issued after release.
- Interrupt pending: irq_p = mstatus_mie & ((ext_irq & mie_meie) | (tmr_irq & mie_mtie)).
- IDLE priority, evaluated only when mem_valid=1:
  - mem_ecall first: cap_epc=mem_pc, cap_cause=ECALL_CAUSE, cap_irq=0, go to TRAP.
  - else mem_mret: go to MRET. A pending interrupt waits until MRET completes.
  - else irq_p: cap_epc=mem_pc (MEM instruction squashed, re-executed after return), cap_irq=1, go to TRAP.
  - cap_cause on interrupt: EXT_CAUSE if the external interrupt is enabled and pending, else TMR_CAUSE. External has priority over timer.
- mem_valid=0 (bubble): no trap is taken this cycle; interrupts wait for a valid instruction.
- TRAP (1 cycle):
  - flush=1, mepc_we=1, mepc_wdata=cap_epc.
  - mcause_we=1, mcause_wdata = {cap_irq, cap_cause zero-extended to XLEN-1}.
  - mstatus_trap=1.
  - Next state REDIRECT.
- REDIRECT (1 cycle):
  - flush=1, redirect_en=1.
  - redirect_pc = {mtvec[XLEN-1:2],2'b00}.
  - Vectored mode (mtvec[1:0]==01) with cap_irq=1: base + (cap_cause<<2), wrapping modulo 2^XLEN.
  - mtvec[1:0] in {10,11} treated as direct.
  - Next state IDLE.
- MRET (1 cycle):
  - flush=1, redirect_en=1, redirect_pc={mepc_in[XLEN-1:2],2'b00}, mstatus_mret=1.
  - Next state IDLE.
- Latency:
  - Trap: detection cycle N; CSR writes in N+1; fetch from handler in N+2.
  - MRET: redirect in N+1.
- Inputs are ignored outside IDLE; flushed instructions cannot retrigger.
- The interrupt is re-sampled in the IDLE cycle after MRET using the restored MIE.
- Back-to-back traps are allowed, with minimum spacing of 1 IDLE cycle.

Decomposition:
- Shared package holds:
  - trap_state_e enum (IDLE, TRAP, REDIRECT, MRET).
  - Cause constants CAUSE_ECALL_M=11, CAUSE_MEI=11, CAUSE_MTI=7.
  - MTVEC_DIRECT=2'b00, MTVEC_VECTORED=2'b01.
- No sub-module; the FSM plus the capture registers form one block.

Test Plan:
- Reset: hold rst=0 with irq/ecall active -> all outputs 0, busy=0; release -> still 0 until mem_valid=1.
- ECALL: mem_valid=1, mem_ecall=1, mem_pc=0x100, mtvec=0x200 ->
  - N+1: flush, mepc_wdata=0x100, mcause_wdata=11, mstatus_trap.
  - N+2: redirect_pc=0x200.
- Vectored timer interrupt: mstatus_mie=1, mie_mtie=1, tmr_irq=1, mem_pc=0x40, mtvec=0x301 ->
  - mcause_wdata=0x80000007.
  - redirect_pc=0x31C.
- Priority: ext_irq and tmr_irq both enabled and pending, and mem_ecall=1 in the same cycle -> ECALL taken (mcause=11). Next instruction with both irqs still pending -> mcause=0x8000000B.
- MRET with pending irq: mem_mret=1, mepc_in=0x104, tmr_irq=1, mstatus_mie=0 ->
  - N+1: redirect_pc=0x104, mstatus_mret.
  - Next IDLE cycle with MIE=1 and mem_valid=1: timer trap taken.
- Reset mid-trap: assert rst in TRAP -> outputs 0 immediately; after release no REDIRECT or CSR write occurs. Also check that mem_valid=0 with irq_p=1 causes no trap.
